icache_responder: RTL

- Instruction-side responder on the datapath/cache interface. Answers imemREN/imemaddr requests with ihit/imemload.
- Direct-mapped, one word per frame, valid+tag per frame.
- On a miss, acts as the initiator toward the memory controller: iREN/iaddr out, iwait/iload in. Fills the frame, then serves the retried request.
- Sits between the pipeline's fetch stage and the memory controller.

---
 rtl/cpu_types_pkg.sv | 34 +++
 rtl/icache_frame_array.sv | 45 ++++
 rtl/icache_responder.sv | 99 +++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction-cache address split, frame layout and FSM states.
package cpu_types_pkg;

  localparam int ICACHE_SETS = 16;
  localparam int ICACHE_IDX  = $clog2(ICACHE_SETS);

  typedef logic [31:0] word_t;

  typedef struct packed {
    logic [29-ICACHE_IDX:0] tag;
    logic [ICACHE_IDX-1:0]  idx;
    logic [1:0]             bytoff;
  } icachef_t;

  // Tag is stored right-aligned in 30 bits so any SETS fits one layout
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    word_t       data;
  } icache_frame_t;

  typedef enum logic {
    IDLE,
    FETCH
  } icache_state_t;

  function automatic logic [29:0] icache_tag(
    input logic [29:0] waddr,
    input int          idx_w
  );
    return waddr >> idx_w;
  endfunction

endpackage

// File: rtl/icache_frame_array.sv
// Direct-mapped frame store: sync write, comb read, global valid clear.
module icache_frame_array
  import cpu_types_pkg::*;
#(
  parameter int SETS = ICACHE_SETS,
  localparam int IDX = $clog2(SETS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            we,
  input  logic [IDX-1:0]  widx,
  input  logic [29:0]     wtag,
  input  logic [31:0]     wdata,
  input  logic [IDX-1:0]  ridx,
  output logic            rvalid,
  output logic [29:0]     rtag,
  output logic [31:0]     rdata
);

  logic [SETS-1:0] valid;
  logic [29:0]     tag_q  [SETS];
  logic [31:0]     data_q [SETS];

  // Clear beats a same-cycle fill
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= '0;
    end else if (we) begin
      valid[widx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[widx]  <= wtag;
      data_q[widx] <= wdata;
    end
  end

  assign rvalid = valid[ridx];
  assign rtag   = tag_q[ridx];
  assign rdata  = data_q[ridx];

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped instruction cache responder with single-word refill.
// Optional same-cycle fill forwarding under ICACHE_FILL_FORWARD_EN.
module icache_responder
  import cpu_types_pkg::*;
#(
  parameter int          SETS    = ICACHE_SETS,
  parameter logic [31:0] PC_INIT = 32'h0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  input  logic        invalidate
);

  localparam int IDX = $clog2(SETS);

  icache_state_t state;
  icache_state_t next_state;
  logic [31:0]   miss_addr;
  icache_frame_t look;
  logic          hit;
  logic          fill;
  logic          unused;

  assign fill = (state == FETCH) && !iwait && !RST;

  icache_frame_array #(
    .SETS(SETS)
  ) u_frames (
    .clk   (CLK),
    .rst   (RST),
    .clear (invalidate),
    .we    (fill),
    .widx  (miss_addr[IDX+1:2]),
    .wtag  (icache_tag(miss_addr[31:2], IDX)),
    .wdata (iload),
    .ridx  (imemaddr[IDX+1:2]),
    .rvalid(look.valid),
    .rtag  (look.tag),
    .rdata (look.data)
  );

  assign hit = imemREN && look.valid && !invalidate
            && (look.tag == icache_tag(imemaddr[31:2], IDX));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      miss_addr <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && imemREN && !hit) begin
        miss_addr <= imemaddr;
      end
    end
  end

  always_comb begin
    next_state = state;
    ihit       = 1'b0;
    imemload   = '0;
    iREN       = 1'b0;
    iaddr      = '0;
    unique case (state)
      IDLE: begin
        ihit     = hit;
        imemload = hit ? look.data : '0;
        if (imemREN && !hit) begin
          next_state = FETCH;
        end
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = {miss_addr[31:2], 2'b00};
        if (!iwait) begin
          next_state = IDLE;
`ifdef ICACHE_FILL_FORWARD_EN
          if (imemREN && !invalidate
              && imemaddr[31:2] == miss_addr[31:2]) begin
            ihit     = 1'b1;
            imemload = iload;
          end
`endif
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign unused = ^{imemaddr[1:0], miss_addr[1:0], PC_INIT};

endmodule
